// File: rtl/nn_pkg.sv
// Shared definitions for the digit-classifier datapath: network geometry,
// fixed-point word format and the pixel loader state encoding.
package nn_pkg;

  localparam int LAYER0_WIDTH = 784;
  localparam int NUM_PIXELS   = LAYER0_WIDTH;
  localparam int PIXEL_BITS   = 8;
  localparam int DATA_WIDTH   = 32;
  localparam int FRAC_BITS    = 16;

  typedef logic [PIXEL_BITS-1:0] pixel_t;
  typedef logic [DATA_WIDTH-1:0] fixed_t;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } loader_state_t;

endpackage

// File: rtl/frame_bank.sv
// One frame worth of network input words: single write port, whole-array
// read-out so the consumer sees every word in parallel.
module frame_bank #(
  parameter int DEPTH  = nn_pkg::NUM_PIXELS,
  parameter int WIDTH  = nn_pkg::DATA_WIDTH,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rd_data [DEPTH]
);

  always_ff @(posedge clk) begin
    if (we) begin
      rd_data[addr] <= wdata;
    end
  end

endmodule

// File: rtl/pixel_frame_loader.sv
// Double-buffered pixel loader: converts 8-bit pixels to network fixed point,
// fills one bank while the other is presented until the consumer acknowledges.
module pixel_frame_loader #(
  parameter int NUM_PIXELS = nn_pkg::NUM_PIXELS,
  parameter int PIXEL_BITS = nn_pkg::PIXEL_BITS,
  parameter int DATA_WIDTH = nn_pkg::DATA_WIDTH,
  parameter int FRAC_BITS  = nn_pkg::FRAC_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PIXEL_BITS-1:0] s_pixel,
  input  logic                  s_sof,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] frame_data [NUM_PIXELS],
  output logic                  frame_valid,
  input  logic                  frame_ack,
  output logic                  sof_err,
  output logic [15:0]           frame_count
);

  import nn_pkg::*;

  localparam int IDX_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam int SHIFT = FRAC_BITS - PIXEL_BITS;

  // Pixel is an unsigned integer intensity; aligning it under the binary
  // point keeps the upper integer bits zero, so no saturation is possible.
  function automatic logic [DATA_WIDTH-1:0] to_fixed(input logic [PIXEL_BITS-1:0] pix);
    logic [DATA_WIDTH-1:0] w;
    w = '0;
    w[PIXEL_BITS-1:0] = pix;
    return w << SHIFT;
  endfunction

  loader_state_t         state, state_nxt;
  logic [IDX_W-1:0]      wr_idx, wr_idx_nxt, wr_addr;
  logic                  wr_bank, wr_bank_nxt;
  logic                  fv_nxt, err_nxt, swap;
  logic [15:0]           cnt_nxt;
  logic                  xfer, last_px;
  logic [DATA_WIDTH-1:0] wr_word;
  logic [DATA_WIDTH-1:0] bank0_q [NUM_PIXELS];
  logic [DATA_WIDTH-1:0] bank1_q [NUM_PIXELS];

  assign s_ready = (state == FILL);
  assign xfer    = s_valid && s_ready;
  assign wr_addr = s_sof ? '0 : wr_idx;
  assign last_px = xfer && (wr_addr == IDX_W'(NUM_PIXELS - 1));
  assign wr_word = to_fixed(s_pixel);

  always_comb begin
    state_nxt   = state;
    wr_idx_nxt  = wr_idx;
    wr_bank_nxt = wr_bank;
    fv_nxt      = frame_valid;
    cnt_nxt     = frame_count;
    err_nxt     = sof_err;
    swap        = 1'b0;
    if (xfer) begin
      wr_idx_nxt = wr_addr + IDX_W'(1);
      if (s_sof && (wr_idx != '0)) begin
        err_nxt = 1'b1;
      end
    end
    case (state)
      FILL: begin
        if (last_px) begin
          wr_idx_nxt = '0;
          // An ack on the same edge frees the read bank, so swap without a bubble.
          if (!frame_valid || frame_ack) begin
            swap = 1'b1;
          end else begin
            state_nxt = FULL;
          end
        end else if (frame_ack) begin
          fv_nxt = 1'b0;
        end
      end
      FULL: begin
        if (frame_ack) begin
          swap      = 1'b1;
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
    if (swap) begin
      wr_bank_nxt = ~wr_bank;
      fv_nxt      = 1'b1;
      cnt_nxt     = frame_count + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= FILL;
      wr_idx      <= '0;
      wr_bank     <= 1'b0;
      frame_valid <= 1'b0;
      frame_count <= '0;
      sof_err     <= 1'b0;
    end else begin
      state       <= state_nxt;
      wr_idx      <= wr_idx_nxt;
      wr_bank     <= wr_bank_nxt;
      frame_valid <= fv_nxt;
      frame_count <= cnt_nxt;
      sof_err     <= err_nxt;
    end
  end

  frame_bank #(.DEPTH(NUM_PIXELS), .WIDTH(DATA_WIDTH), .ADDR_W(IDX_W)) u_bank0 (
    .clk     (clk),
    .we      (xfer && !wr_bank),
    .addr    (wr_addr),
    .wdata   (wr_word),
    .rd_data (bank0_q)
  );

  frame_bank #(.DEPTH(NUM_PIXELS), .WIDTH(DATA_WIDTH), .ADDR_W(IDX_W)) u_bank1 (
    .clk     (clk),
    .we      (xfer && wr_bank),
    .addr    (wr_addr),
    .wdata   (wr_word),
    .rd_data (bank1_q)
  );

  // Read bank is always the one not being written; forced to zero when idle.
  always_comb begin
    for (int i = 0; i < NUM_PIXELS; i++) begin
      if (!frame_valid) begin
        frame_data[i] = '0;
      end else if (wr_bank) begin
        frame_data[i] = bank0_q[i];
      end else begin
        frame_data[i] = bank1_q[i];
      end
    end
  end

endmodule
